// File: rtl/int_ctrl.sv
// Vectored interrupt controller: synchronised sources, edge/level pending latch, mask, GIE and
// fixed lowest-index priority, presented to the CPU through a req/ack/ret handshake.
module int_ctrl #(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  irq_src,
   input  logic        sel,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        int_req,
   output logic [2:0]  int_id,
   input  logic        int_ack,
   input  logic        int_ret
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SVC  = 2'd2
   } state_t;

   localparam logic [7:0] SRC_MSK = 8'((1 << NUM_SRC) - 1);

   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] prev_q;
   logic [7:0] mask_q, mask_d;
   logic [7:0] pend_q, pend_d;
   logic [7:0] trig_q, trig_d;
   logic       gie_q, gie_d;
   state_t     state_q;
   logic       int_req_q;
   logic [2:0] int_id_q;

   logic [7:0] sync_lvl, rise, pend_eff, eligible, w1c, ack_clr;
   logic [2:0] win_id;
   logic       wr_en;

   assign sync_lvl = sync_q[SYNC_STAGES-1];
   assign rise     = sync_lvl & ~prev_q & ~trig_q;
   // Level-mode bits are never stored: they read straight from the synchroniser.
   assign pend_eff = (pend_q & ~trig_q) | (sync_lvl & trig_q);
   assign eligible = pend_eff & mask_q & {8{gie_q}};
   assign wr_en    = sel & we;
   assign ack_clr  = (state_q == ST_REQ && int_ack) ? (8'd1 << int_id_q) : 8'd0;

   always_comb begin
      win_id = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (eligible[i]) win_id = 3'(i);
      end
   end

   always_comb begin
      mask_d = mask_q;
      trig_d = trig_q;
      gie_d  = gie_q;
      w1c    = 8'd0;
      if (wr_en) begin
         case (addr)
            2'd0: mask_d = wdata[7:0] & SRC_MSK;
            2'd1: w1c    = wdata[7:0];
            2'd3: begin
               gie_d  = wdata[0];
               trig_d = wdata[15:8] & SRC_MSK;
            end
            default: ;
         endcase
      end
      // A fresh rising edge beats a same-cycle clear from W1C or ack.
      pend_d = ((pend_q & ~(w1c | ack_clr)) | rise) & ~trig_q & SRC_MSK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'd0;
         prev_q <= 8'd0;
         mask_q <= 8'd0;
         pend_q <= 8'd0;
         trig_q <= 8'd0;
         gie_q  <= 1'b0;
      end else begin
         sync_q[0] <= irq_src & SRC_MSK;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_lvl;
         mask_q <= mask_d;
         pend_q <= pend_d;
         trig_q <= trig_d;
         gie_q  <= gie_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         int_req_q <= 1'b0;
         int_id_q  <= 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|eligible) begin
                  int_id_q  <= win_id;
                  int_req_q <= 1'b1;
                  state_q   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  int_req_q <= 1'b0;
                  state_q   <= ST_SVC;
               end else if (!mask_q[int_id_q] || !gie_q) begin
                  int_req_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            ST_SVC: begin
               if (int_ret) state_q <= ST_IDLE;
            end
            default: begin
               int_req_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rdata = 16'd0;
      if (sel && !we) begin
         case (addr)
            2'd0: rdata = {8'd0, mask_q};
            2'd1: rdata = {8'd0, pend_eff};
            2'd2: rdata = {9'd0, int_id_q, 2'b00, state_q};
            2'd3: rdata = {trig_q, 7'd0, gie_q};
            default: rdata = 16'd0;
         endcase
      end
   end

   assign int_req = int_req_q;
   assign int_id  = int_id_q;

endmodule
